// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets NUM_REQ packet sources share one UART byte
// transmitter. A grant lasts a whole packet; bytes are fetched by byte_idx,
// strobed out with send_en, and paced by the transmitter's send_busy handshake.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_len,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           byte_idx,
  output logic [NUM_REQ-1:0]   done,
  output logic                 timeout_err,
  output logic                 send_en,
  output logic [7:0]           send_data,
  input  logic                 send_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    WAIT_ACK,
    WAIT_DONE,
    FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [7:0]         byte_idx_q, byte_idx_d;
  logic [7:0]         len_q, len_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               send_en_q, send_en_d;
  logic [7:0]         send_data_q, send_data_d;
  logic               timeout_err_q, timeout_err_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               win_vld;
  logic [7:0]         win_len;
  logic [7:0]         cur_data;
  logic               last_byte;

  // Round-robin search for the first requester after rr_ptr
  always_comb begin
    win_idx  = '0;
    win_vld  = 1'b0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_vld && req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign win_len   = req_len[{win_idx, 3'b000} +: 8];
  assign cur_data  = req_data[{owner_q, 3'b000} +: 8];
  assign last_byte = ((byte_idx_q + 8'd1) == len_q);

  // Next-state and next-output logic for the packet sequencer
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    done_d        = '0;
    byte_idx_d    = byte_idx_q;
    len_d         = len_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    send_en_d     = 1'b0;
    send_data_d   = send_data_q;
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = tmo_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d    = NUM_REQ'(1'b1) << win_idx;
          owner_d    = win_idx;
          byte_idx_d = 8'd0;
          len_d      = win_len;
          state_d    = (win_len == 8'd0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        send_data_d = cur_data;
        state_d     = STROBE;
      end
      STROBE: begin
        if (!send_busy) begin
          send_en_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (send_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: flag it and move on as if sent
          timeout_err_d = 1'b1;
          if (last_byte) begin
            state_d = FINISH;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
            state_d    = LOAD;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!send_busy) begin
          if (last_byte) begin
            state_d = FINISH;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
            state_d    = LOAD;
          end
        end
      end
      FINISH: begin
        done_d   = grant_q;
        grant_d  = '0;
        rr_ptr_d = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; rr_ptr resets to the last channel so channel 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      done_q        <= '0;
      byte_idx_q    <= 8'd0;
      len_q         <= 8'd0;
      owner_q       <= '0;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      send_en_q     <= 1'b0;
      send_data_q   <= 8'd0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      byte_idx_q    <= byte_idx_d;
      len_q         <= len_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      send_en_q     <= send_en_d;
      send_data_q   <= send_data_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign byte_idx    = byte_idx_q;
  assign send_en     = send_en_q;
  assign send_data   = send_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester data tables, a reactive transmitter busy
// model, an event monitor, and a packet-level round-robin reference model.
module tb_uart_tx_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*8-1:0] req_len = '0;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [7:0]     byte_idx;
  logic [7:0]     send_data;
  logic           timeout_err;
  logic           send_en;
  logic           send_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] pkt_data [N][256];
  int         lens [N];
  int         model_ptr;

  // transmitter model controls and state
  int ack_dly    = 0;
  int busy_len   = 1;
  bit force_busy = 1'b0;
  bit stuck_low  = 1'b0;
  int pend       = -1;
  int bcnt       = 0;

  // monitor records
  int tx_own[$], tx_idx[$], tx_dat[$];
  int done_v[$], done_cyc[$], done_gnt[$];
  int gnt_v[$], gnt_cyc[$];
  int se_cyc  = -1;
  int te_cyc  = -1;
  int dbl_cnt = 0;
  logic         prev_se  = 1'b0;
  logic [N-1:0] prev_gnt = '0;

  uart_tx_arb #(.NUM_REQ(N), .ACK_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_len    (req_len),
    .req_data   (req_data),
    .grant      (grant),
    .byte_idx   (byte_idx),
    .done       (done),
    .timeout_err(timeout_err),
    .send_en    (send_en),
    .send_data  (send_data),
    .send_busy  (send_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters present the byte addressed by byte_idx
  always_comb begin
    for (int c = 0; c < N; c++) req_data[c*8 +: 8] = pkt_data[c][byte_idx];
  end

  // Transmitter: busy rises ack_dly cycles after a strobe and lasts busy_len cycles
  always @(negedge clk) begin
    if (rst) begin
      send_busy = 1'b0; pend = -1; bcnt = 0;
    end else if (force_busy) begin
      send_busy = 1'b1; bcnt = 0; pend = -1;
    end else if (stuck_low) begin
      send_busy = 1'b0; pend = -1;
    end else if (send_busy) begin
      bcnt--;
      if (bcnt <= 0) send_busy = 1'b0;
    end else begin
      if (send_en) pend = ack_dly;
      if (pend == 0) begin
        send_busy = 1'b1; bcnt = busy_len; pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
    end
  end

  function automatic int onehot2idx(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Event monitor
  always @(negedge clk) begin
    if (send_en) begin
      tx_own.push_back(onehot2idx(grant));
      tx_idx.push_back(int'(byte_idx));
      tx_dat.push_back(int'(send_data));
      if (se_cyc < 0) se_cyc = cyc;
      if (prev_se) dbl_cnt++;
    end
    prev_se = send_en;
    if (done != '0) begin
      done_v.push_back(int'(done));
      done_cyc.push_back(cyc);
      done_gnt.push_back(int'(grant));
    end
    if (grant != '0 && prev_gnt == '0) begin
      gnt_v.push_back(int'(grant));
      gnt_cyc.push_back(cyc);
    end
    prev_gnt = grant;
    if (timeout_err === 1'b1 && te_cyc < 0) te_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requesting channel after the pointer
  function automatic int rr_next(input logic [N-1:0] s, input int p);
    int c;
    for (int k = 1; k <= int'(N); k++) begin
      c = (p + k) % int'(N);
      if (s[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    tx_own.delete(); tx_idx.delete(); tx_dat.delete();
    done_v.delete(); done_cyc.delete(); done_gnt.delete();
    gnt_v.delete(); gnt_cyc.delete();
    se_cyc = -1; te_cyc = -1; dbl_cnt = 0;
  endtask

  task automatic set_len(input int c, input int l);
    lens[c] = l;
    req_len[c*8 +: 8] = 8'(l);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick(2);
    rst = 1'b0;
    model_ptr = N - 1;
    tick(1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (done_v.size() < n && t < budget) begin
      tick(1);
      t++;
    end
  endtask

  // Hold req=s until npkts packets complete, then compare against the packet model
  task automatic run_round(input string tag, input logic [N-1:0] s, input int npkts,
                           input int budget, output int apply_cyc);
    int tp = 0;
    int o;
    clear_mon();
    apply_cyc = cyc;
    req = s;
    wait_done(npkts, budget);
    req = '0;
    tick(4);
    chk({tag, "_done_count"}, 32'(done_v.size()), 32'(npkts));
    for (int k = 0; k < npkts && k < done_v.size() && k < gnt_v.size(); k++) begin
      o = rr_next(s, model_ptr);
      chk({tag, "_grant"}, 32'(gnt_v[k]), 32'(1 << o));
      chk({tag, "_done"}, 32'(done_v[k]), 32'(1 << o));
      chk({tag, "_grant_clear_at_done"}, 32'(done_gnt[k]), 32'd0);
      if (k == 0) chk({tag, "_first_grant_cyc"}, 32'(gnt_cyc[0]), 32'(apply_cyc + 1));
      else        chk({tag, "_done_to_grant"}, 32'(gnt_cyc[k]), 32'(done_cyc[k-1] + 1));
      for (int b = 0; b < lens[o]; b++) begin
        if (tp < tx_dat.size()) begin
          chk({tag, "_tx_owner"}, 32'(tx_own[tp]), 32'(o));
          chk({tag, "_tx_idx"}, 32'(tx_idx[tp]), 32'(b));
          chk({tag, "_tx_data"}, 32'(tx_dat[tp]), 32'(pkt_data[o][b]));
        end
        tp++;
      end
      model_ptr = o;
    end
    chk({tag, "_tx_count"}, 32'(tx_dat.size()), 32'(tp));
    chk({tag, "_double_strobe"}, 32'(dbl_cnt), 32'd0);
  endtask

  initial begin
    int ac;
    int t;
    int np;
    logic [N-1:0] s;

    for (int c = 0; c < N; c++) begin
      lens[c] = 0;
      for (int b = 0; b < 256; b++) pkt_data[c][b] = 8'h00;
    end

    // reset state
    tick(3);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_send_en", 32'(send_en), 32'd0);
    chk("rst_send_data", 32'(send_data), 32'd0);
    chk("rst_byte_idx", 32'(byte_idx), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    model_ptr = N - 1;
    tick(1);

    // single 3-byte packet, 10-cycle transmitter
    ack_dly = 0; busy_len = 10;
    set_len(0, 3);
    pkt_data[0][0] = 8'h41; pkt_data[0][1] = 8'h42; pkt_data[0][2] = 8'h43;
    run_round("single", 4'b0001, 1, 200, ac);

    // contention after reset: channel 0 first, then rotation
    do_reset();
    busy_len = 3;
    for (int c = 0; c < N; c++) begin
      set_len(c, 1);
      pkt_data[c][0] = 8'(8'hA0 + c);
    end
    run_round("contend", 4'b1111, 5, 300, ac);

    // zero length packet
    set_len(2, 0);
    run_round("zero", 4'b0100, 1, 50, ac);
    if (done_cyc.size() > 0) chk("zero_done_latency", 32'(done_cyc[0] - ac), 32'd2);

    // busy hold-off in STROBE
    set_len(1, 1);
    pkt_data[1][0] = 8'h5A;
    clear_mon();
    force_busy = 1'b1;
    tick(1);
    req = 4'b0010;
    tick(20);
    chk("holdoff_no_strobe", 32'(tx_dat.size()), 32'd0);
    chk("holdoff_grant", 32'(grant), 32'(4'b0010));
    force_busy = 1'b0;
    wait_done(1, 100);
    req = '0;
    tick(3);
    chk("holdoff_one_strobe", 32'(tx_dat.size()), 32'd1);
    if (tx_dat.size() > 0) chk("holdoff_data", 32'(tx_dat[0]), 32'h5A);
    chk("holdoff_done_count", 32'(done_v.size()), 32'd1);
    if (done_v.size() > 0) chk("holdoff_done", 32'(done_v[0]), 32'(4'b0010));
    model_ptr = 1;

    // acknowledge timeout
    set_len(3, 1);
    pkt_data[3][0] = 8'hC3;
    clear_mon();
    chk("tmo_clear_before", 32'(timeout_err), 32'd0);
    stuck_low = 1'b1;
    req = 4'b1000;
    wait_done(1, 300);
    req = '0;
    tick(2);
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_latency", 32'(te_cyc - se_cyc), 32'(TMO));
    chk("tmo_done_count", 32'(done_v.size()), 32'd1);
    if (done_v.size() > 0) chk("tmo_done", 32'(done_v[0]), 32'(4'b1000));
    chk("tmo_strobes", 32'(tx_dat.size()), 32'd1);
    stuck_low = 1'b0;
    model_ptr = 3;
    tick(5);
    chk("tmo_sticky", 32'(timeout_err), 32'd1);

    // reset in the middle of a 5-byte packet
    ack_dly = 1; busy_len = 4;
    set_len(2, 5);
    for (int b = 0; b < 5; b++) pkt_data[2][b] = 8'(8'h10 + b);
    clear_mon();
    req = 4'b0100;
    t = 0;
    while (tx_dat.size() < 2 && t < 200) begin
      tick(1);
      t++;
    end
    chk("midrst_reached_byte2", 32'(tx_dat.size() >= 2), 32'd1);
    rst = 1'b1;
    req = '0;
    tick(1);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_send_en", 32'(send_en), 32'd0);
    chk("midrst_byte_idx", 32'(byte_idx), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
    chk("midrst_send_data", 32'(send_data), 32'd0);
    rst = 1'b0;
    model_ptr = N - 1;
    for (int c = 0; c < N; c++) set_len(c, 1);
    run_round("post_rst", 4'b1111, 1, 100, ac);
    if (gnt_v.size() > 0) chk("post_rst_first_grant", 32'(gnt_v[0]), 32'(4'b0001));

    // randomized rounds against the packet model
    for (int r = 0; r < 8; r++) begin
      s = N'($urandom_range(1, (1 << N) - 1));
      for (int c = 0; c < N; c++) begin
        set_len(c, int'($urandom_range(0, 6)));
        for (int b = 0; b < 8; b++) pkt_data[c][b] = 8'($urandom);
      end
      ack_dly  = int'($urandom_range(0, 3));
      busy_len = int'($urandom_range(1, 6));
      np       = int'($urandom_range(2, 6));
      run_round("rand", s, np, np * 200, ac);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
